// File: rtl/tile_scan.sv
// ============================================================================
// Module   : tile_scan
// Purpose  : Raster-order pixel position tracker. Cascaded counters give
//            registered tile column/row, in-tile pixel offsets and a linear
//            physical tile number that includes a frame-latched vertical
//            scroll in whole tile rows. No divider; one adder forms the
//            tile number.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tile_scan #(
  parameter int SCREEN_WIDTH     = 1280,
  parameter int SCREEN_HEIGHT    = 720,
  parameter int TILE_WIDTH       = 16,
  parameter int TILE_HEIGHT      = 24,
  parameter int TILES_X          = SCREEN_WIDTH / TILE_WIDTH,
  parameter int TILES_Y          = SCREEN_HEIGHT / TILE_HEIGHT,
  parameter int TILE_WIDTH_BITS  = $clog2(TILE_WIDTH),
  parameter int TILE_HEIGHT_BITS = $clog2(TILE_HEIGHT),
  parameter int TILE_X_BITS      = $clog2(TILES_X),
  parameter int TILE_Y_BITS      = $clog2(TILES_Y),
  parameter int TILE_NUM_BITS    = $clog2(TILES_X * TILES_Y)
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic                        in_frame_start,
  input  logic                        in_pix_valid,
  input  logic [TILE_Y_BITS-1:0]      in_scroll_row,
  output logic                        out_valid,
  output logic [TILE_X_BITS-1:0]      out_tile_x,
  output logic [TILE_Y_BITS-1:0]      out_tile_y,
  output logic [TILE_NUM_BITS-1:0]    out_tile_num,
  output logic [TILE_WIDTH_BITS-1:0]  out_tile_pix_x,
  output logic [TILE_HEIGHT_BITS-1:0] out_tile_pix_y,
  output logic                        out_tile_first,
  output logic                        out_overrun
);

  localparam int TILE_COUNT = TILES_X * TILES_Y;

  localparam logic [TILE_WIDTH_BITS-1:0]  PIX_X_LAST    = TILE_WIDTH_BITS'(TILE_WIDTH - 1);
  localparam logic [TILE_HEIGHT_BITS-1:0] PIX_Y_LAST    = TILE_HEIGHT_BITS'(TILE_HEIGHT - 1);
  localparam logic [TILE_X_BITS-1:0]      TILE_X_LAST   = TILE_X_BITS'(TILES_X - 1);
  localparam logic [TILE_Y_BITS-1:0]      TILE_Y_LAST   = TILE_Y_BITS'(TILES_Y - 1);
  localparam logic [TILE_NUM_BITS-1:0]    ROW_STEP      = TILE_NUM_BITS'(TILES_X);
  localparam logic [TILE_NUM_BITS-1:0]    ROW_BASE_LAST = TILE_NUM_BITS'(TILE_COUNT - TILES_X);

  // Position of the next pixel to be accepted
  logic [TILE_WIDTH_BITS-1:0]  pix_x;
  logic [TILE_X_BITS-1:0]      tile_x;
  logic [TILE_HEIGHT_BITS-1:0] pix_y;
  logic [TILE_Y_BITS-1:0]      tile_y;
  logic [TILE_NUM_BITS-1:0]    row_base;     // physical row * TILES_X
  logic [TILE_NUM_BITS-1:0]    scroll_base;  // latched scroll * TILES_X
  logic                        past_end;     // frame already fully consumed

  // Position seen by this cycle's pixel (frame start overrides stored state)
  logic [TILE_WIDTH_BITS-1:0]  cur_pix_x;
  logic [TILE_X_BITS-1:0]      cur_tile_x;
  logic [TILE_HEIGHT_BITS-1:0] cur_pix_y;
  logic [TILE_Y_BITS-1:0]      cur_tile_y;
  logic [TILE_NUM_BITS-1:0]    cur_row_base;
  logic [TILE_NUM_BITS-1:0]    cur_scroll_base;
  logic                        cur_past_end;

  logic [TILE_WIDTH_BITS-1:0]  nxt_pix_x;
  logic [TILE_X_BITS-1:0]      nxt_tile_x;
  logic [TILE_HEIGHT_BITS-1:0] nxt_pix_y;
  logic [TILE_Y_BITS-1:0]      nxt_tile_y;
  logic [TILE_NUM_BITS-1:0]    nxt_row_base;
  logic                        nxt_past_end;

  logic [TILE_Y_BITS-1:0]      scroll_eff;
  logic [TILE_NUM_BITS-1:0]    scroll_base_new;
  logic [TILE_NUM_BITS-1:0]    tile_num_cur;

  // Out-of-range scroll requests fall back to no scroll
  always_comb begin
    scroll_eff = in_scroll_row;
    if (32'(in_scroll_row) >= TILES_Y) begin
      scroll_eff = '0;
    end
  end

  // Constant multiply; only used when a frame starts
  assign scroll_base_new = TILE_NUM_BITS'(scroll_eff) * ROW_STEP;

  // Select stored position or a fresh frame origin for the current pixel
  always_comb begin
    cur_pix_x       = pix_x;
    cur_tile_x      = tile_x;
    cur_pix_y       = pix_y;
    cur_tile_y      = tile_y;
    cur_row_base    = row_base;
    cur_scroll_base = scroll_base;
    cur_past_end    = past_end;
    if (in_frame_start) begin
      cur_pix_x       = '0;
      cur_tile_x      = '0;
      cur_pix_y       = '0;
      cur_tile_y      = '0;
      cur_row_base    = scroll_base_new;
      cur_scroll_base = scroll_base_new;
      cur_past_end    = 1'b0;
    end
  end

  // The single adder producing the physical tile index
  assign tile_num_cur = cur_row_base + TILE_NUM_BITS'(cur_tile_x);

  // Cascaded counter advance after an accepted pixel
  always_comb begin
    nxt_pix_x    = cur_pix_x;
    nxt_tile_x   = cur_tile_x;
    nxt_pix_y    = cur_pix_y;
    nxt_tile_y   = cur_tile_y;
    nxt_row_base = cur_row_base;
    nxt_past_end = cur_past_end;
    if (in_pix_valid) begin
      nxt_pix_x = cur_pix_x + 1'b1;
      if (cur_pix_x == PIX_X_LAST) begin
        nxt_pix_x  = '0;
        nxt_tile_x = cur_tile_x + 1'b1;
        if (cur_tile_x == TILE_X_LAST) begin
          nxt_tile_x = '0;
          nxt_pix_y  = cur_pix_y + 1'b1;
          if (cur_pix_y == PIX_Y_LAST) begin
            nxt_pix_y    = '0;
            nxt_tile_y   = cur_tile_y + 1'b1;
            // Compare before adding so the base never needs an extra bit
            nxt_row_base = (cur_row_base == ROW_BASE_LAST) ? '0 : cur_row_base + ROW_STEP;
            if (cur_tile_y == TILE_Y_LAST) begin
              // Ran off the bottom without a frame start: restart the raster
              nxt_tile_y   = '0;
              nxt_row_base = cur_scroll_base;
              nxt_past_end = 1'b1;
            end
          end
        end
      end
    end
  end

  // Position counters and frame-latched scroll state
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      pix_x       <= '0;
      tile_x      <= '0;
      pix_y       <= '0;
      tile_y      <= '0;
      row_base    <= '0;
      scroll_base <= '0;
      past_end    <= 1'b0;
    end else begin
      pix_x       <= nxt_pix_x;
      tile_x      <= nxt_tile_x;
      pix_y       <= nxt_pix_y;
      tile_y      <= nxt_tile_y;
      row_base    <= nxt_row_base;
      scroll_base <= cur_scroll_base;
      past_end    <= nxt_past_end;
    end
  end

  // Registered outputs; coordinates hold while no pixel is presented
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_valid      <= 1'b0;
      out_tile_x     <= '0;
      out_tile_y     <= '0;
      out_tile_num   <= '0;
      out_tile_pix_x <= '0;
      out_tile_pix_y <= '0;
      out_tile_first <= 1'b0;
      out_overrun    <= 1'b0;
    end else begin
      out_valid      <= in_pix_valid;
      out_tile_first <= in_pix_valid && (cur_pix_x == '0);
      out_overrun    <= (out_overrun && !in_frame_start) || (in_pix_valid && cur_past_end);
      if (in_pix_valid) begin
        out_tile_x     <= cur_tile_x;
        out_tile_y     <= cur_tile_y;
        out_tile_num   <= tile_num_cur;
        out_tile_pix_x <= cur_pix_x;
        out_tile_pix_y <= cur_pix_y;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_scan.sv
// ============================================================================
// Module   : tb_tile_scan
// Purpose  : Self-checking bench for tile_scan. A full-size instance covers
//            reset, stepping and line/row advance; a small-screen instance
//            (64x48, 16x8 tiles -> 4x6 tiles) covers scroll wrap, overrun and
//            frame restarts within a short run.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tile_scan;

  typedef struct packed {
    logic v;
    int   tx;
    int   ty;
    int   num;
    int   px;
    int   py;
    logic first;
    logic ovr;
  } exp_t;

  typedef struct packed {
    int   idx;   // pixels accepted since frame start / reset
    int   scr;   // latched scroll in tile rows
    exp_t last;  // what the outputs should currently show
  } mdl_t;

  typedef struct packed {
    logic fs;
    logic pv;
    int   scr;
    int   reps;
    exp_t want;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Full-size instance
  logic        a_fs, a_pv;
  logic [4:0]  a_scroll;
  logic        a_valid, a_first, a_ovr;
  logic [6:0]  a_tx;
  logic [4:0]  a_ty;
  logic [11:0] a_num;
  logic [3:0]  a_px;
  logic [4:0]  a_py;

  // Small-screen instance
  logic        b_fs, b_pv;
  logic [2:0]  b_scroll;
  logic        b_valid, b_first, b_ovr;
  logic [1:0]  b_tx;
  logic [2:0]  b_ty;
  logic [4:0]  b_num;
  logic [3:0]  b_px;
  logic [2:0]  b_py;

  mdl_t ma, mb;

  tile_scan dut_a (
    .in_clk(clk), .in_rst(rst), .in_frame_start(a_fs), .in_pix_valid(a_pv),
    .in_scroll_row(a_scroll), .out_valid(a_valid), .out_tile_x(a_tx),
    .out_tile_y(a_ty), .out_tile_num(a_num), .out_tile_pix_x(a_px),
    .out_tile_pix_y(a_py), .out_tile_first(a_first), .out_overrun(a_ovr)
  );

  tile_scan #(
    .SCREEN_WIDTH(64), .SCREEN_HEIGHT(48), .TILE_WIDTH(16), .TILE_HEIGHT(8)
  ) dut_b (
    .in_clk(clk), .in_rst(rst), .in_frame_start(b_fs), .in_pix_valid(b_pv),
    .in_scroll_row(b_scroll), .out_valid(b_valid), .out_tile_x(b_tx),
    .out_tile_y(b_ty), .out_tile_num(b_num), .out_tile_pix_x(b_px),
    .out_tile_pix_y(b_py), .out_tile_first(b_first), .out_overrun(b_ovr)
  );

  function automatic exp_t mk(logic v, int tx, int ty, int num, int px, int py,
                              logic first, logic ovr);
    exp_t e;
    e.v = v; e.tx = tx; e.ty = ty; e.num = num; e.px = px; e.py = py;
    e.first = first; e.ovr = ovr;
    return e;
  endfunction

  function automatic vec_t mkv(logic fs, logic pv, int scr, int reps, exp_t want);
    vec_t t;
    t.fs = fs; t.pv = pv; t.scr = scr; t.reps = reps; t.want = want;
    return t;
  endfunction

  // Reference: position of pixel number p straight from division/modulo
  function automatic exp_t pixel_exp(int p, int scr, int w, int h, int tw, int th);
    int tot, q, x, y;
    exp_t e;
    tot = w * h;
    q = p % tot;
    x = q % w;
    y = q / w;
    e.v     = 1'b1;
    e.tx    = x / tw;
    e.px    = x % tw;
    e.ty    = y / th;
    e.py    = y % th;
    e.num   = ((e.ty + scr) % (h / th)) * (w / tw) + e.tx;
    e.first = (e.px == 0);
    e.ovr   = (p >= tot);
    return e;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.idx = 0;
    m.scr = 0;
    m.last = mk(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    return m;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, logic fs, logic pv, int scr,
                                    int w, int h, int tw, int th);
    mdl_t r;
    r = m;
    if (fs) begin
      r.scr = (scr >= h / th) ? 0 : scr;
      r.idx = 0;
      r.last.ovr = 1'b0;
    end
    if (pv) begin
      r.last = pixel_exp(r.idx, r.scr, w, h, tw, th);
      r.idx = r.idx + 1;
    end else begin
      r.last.v = 1'b0;
      r.last.first = 1'b0;
    end
    return r;
  endfunction

  function automatic exp_t act_a();
    return mk(a_valid, int'(a_tx), int'(a_ty), int'(a_num), int'(a_px), int'(a_py), a_first, a_ovr);
  endfunction

  function automatic exp_t act_b();
    return mk(b_valid, int'(b_tx), int'(b_ty), int'(b_num), int'(b_px), int'(b_py), b_first, b_ovr);
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("v%0d tx%0d ty%0d num%0d px%0d py%0d first%0d ovr%0d",
                     e.v, e.tx, e.ty, e.num, e.px, e.py, e.first, e.ovr);
  endfunction

  task automatic cmp(string name, exp_t got, exp_t want);
    checks++;
    if (got.v !== want.v || got.tx != want.tx || got.ty != want.ty ||
        got.num != want.num || got.px != want.px || got.py != want.py ||
        got.first !== want.first || got.ovr !== want.ovr) begin
      errors++;
      $display("FAIL %s: got [%s] want [%s]", name, fmt(got), fmt(want));
    end
  endtask

  task automatic step_a(logic fs, logic pv, int scr);
    a_fs = fs;
    a_pv = pv;
    a_scroll = 5'(scr);
    @(posedge clk);
    #1;
    ma = mdl_next(ma, fs, pv, scr, 1280, 720, 16, 24);
    a_fs = 1'b0;
    a_pv = 1'b0;
  endtask

  task automatic step_b(logic fs, logic pv, int scr);
    b_fs = fs;
    b_pv = pv;
    b_scroll = 3'(scr);
    @(posedge clk);
    #1;
    mb = mdl_next(mb, fs, pv, scr, 64, 48, 16, 8);
    b_fs = 1'b0;
    b_pv = 1'b0;
  endtask

  // Hard stop in case the run ever stalls
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[12];
    logic pv, fs;
    int   scr;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_fs = 0; a_pv = 0; a_scroll = '0;
    b_fs = 0; b_pv = 0; b_scroll = '0;
    ma = mdl_reset();
    mb = mdl_reset();

    repeat (3) @(posedge clk);
    #1;
    cmp("reset_a", act_a(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    cmp("reset_b", act_b(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    // {fs, pv, scroll, repeat count, outputs after the last repeat}
    tab[0]  = mkv(1, 1, 0,  1,    mk(1, 0,  0, 0,    0,  0, 1, 0));
    tab[1]  = mkv(0, 1, 0,  15,   mk(1, 0,  0, 0,    15, 0, 0, 0));
    tab[2]  = mkv(0, 1, 0,  1,    mk(1, 1,  0, 1,    0,  0, 1, 0));
    tab[3]  = mkv(0, 1, 0,  1,    mk(1, 1,  0, 1,    1,  0, 0, 0));
    tab[4]  = mkv(0, 0, 0,  3,    mk(0, 1,  0, 1,    1,  0, 0, 0));
    tab[5]  = mkv(1, 0, 5,  1,    mk(0, 1,  0, 1,    1,  0, 0, 0));
    tab[6]  = mkv(0, 1, 7,  1,    mk(1, 0,  0, 400,  0,  0, 1, 0));
    tab[7]  = mkv(1, 1, 30, 1,    mk(1, 0,  0, 0,    0,  0, 1, 0));
    tab[8]  = mkv(0, 1, 0,  1279, mk(1, 79, 0, 79,   15, 0, 0, 0));
    tab[9]  = mkv(0, 1, 0,  1,    mk(1, 0,  0, 0,    0,  1, 1, 0));
    tab[10] = mkv(1, 1, 29, 1,    mk(1, 0,  0, 2320, 0,  0, 1, 0));
    tab[11] = mkv(0, 1, 0,  16,   mk(1, 1,  0, 2321, 0,  0, 1, 0));

    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < tab[i].reps; r++) begin
        step_a((r == 0) ? tab[i].fs : 1'b0, tab[i].pv, tab[i].scr);
      end
      cmp($sformatf("vec%0d", i), act_a(), tab[i].want);
    end

    // Reset mid-line: outputs clear before the next edge
    step_a(0, 1, 0);
    rst = 1'b1;
    #1;
    cmp("rst_async_a", act_a(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    cmp("rst_async_b", act_b(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    ma = mdl_reset();
    mb = mdl_reset();
    step_a(0, 1, 0);
    cmp("first_after_rst", act_a(), mk(1, 0, 0, 0, 0, 0, 1, 0));

    // Line/tile-row advance with random gaps, every cycle against the model
    step_a(1, 1, 0);
    cmp("gap_model", act_a(), ma.last);
    for (int n = 0; n < 60000 && ma.idx < 32038; n++) begin
      pv = ($urandom_range(15) != 0);
      step_a(0, pv, 0);
      cmp("gap_model", act_a(), ma.last);
    end
    cmp("line25_px37", act_a(), mk(1, 2, 1, 82, 5, 1, 0, 0));

    // Small screen, scroll 5: last line wraps the physical row
    step_b(1, 1, 5);
    cmp("b_scroll5_first", act_b(), mk(1, 0, 0, 20, 0, 0, 1, 0));
    for (int n = 0; n < 5000 && mb.idx < 3009; n++) begin
      step_b(0, 1, 3);
      cmp("b_scroll_model", act_b(), mb.last);
    end
    cmp("b_last_line", act_b(), mk(1, 0, 5, 16, 0, 7, 1, 0));

    // One pixel past the frame raises the sticky overrun
    step_b(1, 1, 0);
    for (int n = 0; n < 5000 && mb.idx < 3073; n++) begin
      step_b(0, 1, 0);
      cmp("b_ovr_model", act_b(), mb.last);
    end
    cmp("b_overrun", act_b(), mk(1, 0, 0, 0, 0, 0, 1, 1));
    step_b(0, 0, 0);
    cmp("b_overrun_hold", act_b(), mk(0, 0, 0, 0, 0, 0, 0, 1));
    step_b(1, 0, 0);
    cmp("b_overrun_clr", act_b(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    step_b(1, 1, 6);
    cmp("b_scroll_oob", act_b(), mk(1, 0, 0, 0, 0, 0, 1, 0));

    // Frame start together with a pixel mid-frame
    for (int n = 0; n < 100; n++) step_b(0, 1, 0);
    step_b(1, 1, 2);
    cmp("b_fs_with_pix", act_b(), mk(1, 0, 0, 8, 0, 0, 1, 0));

    // Random traffic: gaps, rare restarts, arbitrary scroll requests
    for (int n = 0; n < 6000; n++) begin
      fs  = ($urandom_range(1999) == 0);
      pv  = ($urandom_range(7) != 0);
      scr = int'($urandom_range(7));
      step_b(fs, pv, scr);
      cmp("b_rand", act_b(), mb.last);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tile_scan.md
# tile_scan

Sequential, divider-free successor to the combinational pixel-to-tile mapper. It tracks the raster position of a streamed pixel sequence with cascaded counters and emits registered tile coordinates, in-tile pixel offsets and a linear tile number. The tile number includes a frame-latched vertical scroll in whole tile rows, so the text buffer can be used as a circular line buffer. It sits between the video sync generator and the text/character-ROM fetch stage of the display pipeline.

## Interface
- SCREEN_WIDTH, 1280, visible pixels per line
- SCREEN_HEIGHT, 720, visible lines per frame
- TILE_WIDTH, 16, pixels per tile horizontally
- TILE_HEIGHT, 24, pixels per tile vertically
- TILES_X, SCREEN_WIDTH / TILE_WIDTH, tiles per row (80)
- TILES_Y, SCREEN_HEIGHT / TILE_HEIGHT, tile rows (30)
- TILE_WIDTH_BITS / TILE_HEIGHT_BITS, $clog2 of tile dims
- TILE_X_BITS / TILE_Y_BITS / TILE_NUM_BITS, $clog2(TILES_X) / $clog2(TILES_Y) / $clog2(TILES_X*TILES_Y)

Ports:
- in_clk  in  1  pixel clock
- in_rst  in  1  asynchronous, active-high reset
- in_frame_start  in  1  one-cycle pulse marking the start of a frame
- in_pix_valid  in  1  one visible pixel this cycle, in raster order
- in_scroll_row  in  TILE_Y_BITS  tile-row scroll, sampled at frame start
- out_valid  out  1  outputs describe a pixel
- out_tile_x  out  TILE_X_BITS  tile column
- out_tile_y  out  TILE_Y_BITS  logical (on-screen) tile row
- out_tile_num  out  TILE_NUM_BITS  physical tile index: ((tile_y + scroll) mod TILES_Y) * TILES_X + tile_x
- out_tile_pix_x  out  TILE_WIDTH_BITS  pixel column inside tile
- out_tile_pix_y  out  TILE_HEIGHT_BITS  pixel row inside tile
- out_tile_first  out  1  pixel is column 0 of its tile (fetch strobe)
- out_overrun  out  1  sticky: more than SCREEN_WIDTH*SCREEN_HEIGHT pixels since frame start

## Operation
- Internal counters: pix_x (0..TILE_WIDTH-1), tile_x (0..TILES_X-1), pix_y (0..TILE_HEIGHT-1), tile_y (0..TILES_Y-1), plus row_base = physical row * TILES_X.
- Each valid pixel: counters describe that pixel. They then advance: pix_x wraps into tile_x; tile_x wrap advances pix_y; pix_y wrap advances tile_y and adds TILES_X to row_base. row_base wraps to 0 when it reaches TILES_X*TILES_Y.
- Tile number = row_base + tile_x. No divide or multiply hardware; one adder only.
- in_frame_start: clears all counters. Latches scroll = in_scroll_row, or 0 if in_scroll_row >= TILES_Y. Loads row_base = scroll * TILES_X using an accumulated add sequence or a constant multiply; either is acceptable as long as the value is ready before the next valid pixel. Clears out_overrun.
- frame_start and pix_valid in the same cycle: frame_start wins, and that pixel is pixel (0,0) with the new scroll.
- in_scroll_row changes mid-frame have no effect until the next frame start.
- Wrap past the last pixel (tile_y wraps without a frame start): counters return to (0,0), row_base returns to scroll*TILES_X, and out_overrun is set and held until the next frame start.
- in_pix_valid low: counters hold; registered outputs hold their last values; out_valid=0; out_tile_first=0.

## Timing
- Latency is exactly 1 cycle: a pixel accepted at edge n appears on the outputs after edge n, alongside out_valid=1.
- Throughput: one pixel per cycle, sustained with no bubbles.
- Reset (async assert, release synchronous to in_clk): all outputs 0, all counters 0, scroll latch 0, row_base 0.
- Reset mid-line aborts the frame. Counting restarts at (0,0) on the first valid pixel after reset, even without a frame start.
- out_tile_first = registered (pix_x == 0 && in_pix_valid).

## Test plan
- Reset: assert in_rst mid-line -> all outputs 0 in the same cycle. First valid pixel after release -> tile_num 0, pix (0,0), out_tile_first=1.
- Horizontal stepping: frame_start (scroll 0) then 18 valid pixels. Pixel 16 -> tile_x 1, pix_x 0, tile_first 1. Pixel 17 -> tile_num 1, pix_x 1, tile_first 0.
- Line and tile-row advance: pixel index 25*1280+37 -> tile_y 1, pix_y 1, tile_x 2, pix_x 5, tile_num 82. Insert random pix_valid gaps -> identical values.
- Scroll: in_scroll_row=5 at frame start. Pixel (0,0) -> tile_num 400. First pixel of line 719 -> tile_y 29, tile_num 320 (wrapped). A mid-frame change to 7 is ignored. in_scroll_row=30 -> treated as 0.
- Overrun: 1280*720+1 valid pixels -> last pixel shows tile_num 0, pix (0,0), overrun=1. Next frame_start -> overrun=0.
- Simultaneous frame_start and pix_valid mid-frame -> next outputs show pixel (0,0), tile_num = new scroll*80.
